window_dma: RTL
===============

# window_dma

- Parametrised window-fetch DMA for the CNN datapath.
- Owns a feature-map RAM with a single-word write port for loading.
- On `start`, streams a WIN_H × WIN_W window from `base_addr`, stepping `row_pitch` words between rows, one full row per beat, with valid/ready backpressure.
- Replaces the fixed 25-word block read. Serves the convolution PE array with arbitrary window origin, pitch and size, plus bounds checking.

## Interface
- DATA_WIDTH, 16: signed word width (Q-format fixed point).
- ADDR_WIDTH, 16: word-address width.
- DEPTH, 2500: RAM words; must be ≤ 2**ADDR_WIDTH.
- WIN_W, 5: words per window row (= output lanes).
- WIN_H, 5: rows per window.
- INIT_VALUE, 16'h0400: time-zero content of every RAM word (1.0 in Q5.10).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  DATA_WIDTH  write data.
- start  in  1  request window fetch; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  address of window element (0,0); sampled with start.
- row_pitch  in  ADDR_WIDTH  word distance between row starts; sampled with start.
- out_valid  out  1  out_data holds a window row.
- out_ready  in  1  consumer accepts row when out_valid && out_ready.
- out_data  out  WIN_W*DATA_WIDTH  row words, lane 0 in LSBs, lane i = ram[row_addr+i].
- out_last  out  1  current row is row WIN_H-1.
- busy  out  1  fetch in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: window out of range, nothing streamed.

## Operation
- States: IDLE, RUN, FIN.
- IDLE:
  - On start, latch base_addr/row_pitch, set row_addr=base_addr and row_cnt=0.
  - Compute end = base_addr + (WIN_H-1)*row_pitch + WIN_W-1 at 2*ADDR_WIDTH+1 bits, no truncation.
  - If end ≥ DEPTH: go to FIN with err=1. Else go to RUN.
- RUN, issue condition (!out_valid || out_ready):
  - Load out_data with the WIN_W words at row_addr and set out_valid.
  - out_last = (row_cnt==WIN_H-1).
  - row_addr += row_pitch; row_cnt++.
- RUN, row exit: when the out_last row handshakes, clear out_valid and go to FIN.
- FIN: done=1 for one cycle, err as decided, then go to IDLE.
- start outside IDLE is ignored.
- Writes:
  - Accepted in any state when wr_en && wr_addr < DEPTH. Out-of-range writes are dropped silently.
  - Same-cycle write and read of one word: the read returns the old value.
  - A write to a window word not yet read during RUN is visible in the stream.
- RAM contents are not cleared by rst. INIT_VALUE applies at time zero only.
- Reset values: state IDLE, out_valid 0, out_last 0, out_data 0, busy 0, done 0, err 0, counters 0.
- rst mid-RUN aborts the fetch: no done, partial row discarded.

## Timing
- start accepted in cycle t (IDLE):
  - busy=1 from t+1.
  - First out_valid at t+2.
- Continuous out_ready: one row per cycle, so rows arrive at t+2 … t+WIN_H+1.
- out_valid=1 && out_ready=0: out_data, out_last and out_valid hold stable; no new issue.
- done pulses in the cycle after the last handshake. busy drops in that same cycle.
- A start coincident with done is ignored. The next start can be accepted the cycle after done.
- Range error: start at t → done=1, err=1 at t+1 (via FIN), out_valid never asserted.
- err is meaningful only while done=1; it reads 0 otherwise.

## Structure
- Package window_dma_pkg:
  - State enum (IDLE, RUN, FIN).
  - Default DATA_WIDTH/ADDR_WIDTH constants.
  - Q-format INIT_VALUE constant.
- Sub-module window_dma_ram:
  - DEPTH × DATA_WIDTH array.
  - One write port.
  - One registered WIN_W-word-wide read of consecutive addresses, with an enable from the issue condition.
  - Synchronous read-before-write.
- The top holds the FSM, address/row counters, bounds check and handshake.

## Test plan
- Default INIT, base 0, pitch 5, out_ready=1: five rows, every lane 16'h0400, out_last only on row 4, done at start+7, err=0.
- Load ram[i]=i for i<100, then base 12, pitch 10: row r lane i = 12+10r+i, e.g. row 4 = {52..56}.
- Same as previous, with out_ready toggling 1,0,0,1…: out_data stable while stalled, exactly five handshakes, rows in order, no duplicates.
- Range error: base 2490, pitch 5 → end 2514 ≥ 2500; done=err=1 one cycle after start, no out_valid. A wr_addr 2600 write leaves RAM unchanged.
- During RUN, write ram[52]=16'h7FFF before row 4 issues: row 4 lane 0 reads 7FFF. A same-cycle write to the address being issued returns the old value.
- Assert rst after row 2 handshake: outputs return to reset values next cycle, no done. A new start then completes normally.

Source files
------------

// File: rtl/window_dma_pkg.sv
// Shared types and default constants for the window-fetch DMA.
package window_dma_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 16;

  // 1.0 in Q5.10
  localparam logic [15:0] INIT_Q5_10_ONE = 16'h0400;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

endpackage

// File: rtl/window_dma_ram.sv
// Feature-map RAM: one write port, one registered WIN_W-word read of consecutive
// addresses. A read and write of the same word in one cycle returns the old value.
module window_dma_ram #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DEPTH      = 2500,
  parameter int                    WIN_W      = 5,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        rd_en,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [WIN_W*DATA_WIDTH-1:0] rd_data
);

  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW1 = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0]       mem [DEPTH] = '{default: INIT_VALUE};
  logic [AW1-1:0]              lane_addr [WIN_W];
  logic [WIN_W*DATA_WIDTH-1:0] rd_d, rd_q;

  for (genvar g = 0; g < WIN_W; g++) begin : g_lane
    assign lane_addr[g] = {1'b0, rd_addr} + AW1'(g);
  end

  // Lanes past the end of the array read as zero rather than aliasing.
  always_comb begin
    rd_d = rd_q;
    if (rd_en) begin
      for (int i = 0; i < WIN_W; i++) begin
        rd_d[i*DATA_WIDTH +: DATA_WIDTH] = (lane_addr[i] < AW1'(DEPTH))
                                           ? mem[lane_addr[i][IW-1:0]] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < AW1'(DEPTH))) mem[wr_addr[IW-1:0]] <= wr_data;
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/window_dma.sv
// Window-fetch DMA: streams a WIN_H x WIN_W window, one row per beat, from an
// owned feature-map RAM with origin/pitch bounds checking and valid/ready output.
module window_dma
  import window_dma_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DEPTH      = 2500,
  parameter int                    WIN_W      = 5,
  parameter int                    WIN_H      = 5,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(INIT_Q5_10_ONE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       base_addr,
  input  logic [ADDR_WIDTH-1:0]       row_pitch,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIN_W*DATA_WIDTH-1:0] out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int EW = 2*ADDR_WIDTH + 1;
  localparam int CW = $clog2(WIN_H + 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
  logic [ADDR_WIDTH-1:0] pitch_q, pitch_d;
  logic [CW-1:0]         row_cnt_q, row_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [EW-1:0]         end_addr;
  logic                  issue;

  // Wide enough that no origin/pitch combination can wrap back into range.
  assign end_addr = EW'(base_addr) + EW'(WIN_H-1) * EW'(row_pitch) + EW'(WIN_W-1);

  assign issue = (state_q == RUN) && (row_cnt_q < CW'(WIN_H)) && (!out_valid_q || out_ready);

  always_comb begin
    state_d     = state_q;
    row_addr_d  = row_addr_q;
    pitch_d     = pitch_q;
    row_cnt_d   = row_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          row_addr_d = base_addr;
          pitch_d    = row_pitch;
          row_cnt_d  = '0;
          if (end_addr >= EW'(DEPTH)) begin
            state_d = FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue) begin
          out_valid_d = 1'b1;
          out_last_d  = (row_cnt_q == CW'(WIN_H-1));
          row_addr_d  = row_addr_q + pitch_q;
          row_cnt_d   = row_cnt_q + CW'(1);
        end else if (out_valid_q && out_ready && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_addr_q  <= '0;
      pitch_q     <= '0;
      row_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_addr_q  <= row_addr_d;
      pitch_q     <= pitch_d;
      row_cnt_q   <= row_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  window_dma_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .WIN_W      (WIN_W),
    .INIT_VALUE (INIT_VALUE)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (issue),
    .rd_addr (row_addr_q),
    .rd_data (out_data)
  );

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
